mem_port_ctrl: RTL
==================

# mem_port_ctrl

Initiator-side controller for the 8-bit-wide, 2**AW-deep data memory of the 9-bit CPU. Accepts load, store and block-fill requests from the execute stage over a valid/ready handshake, drives the memory's address, read-enable, write-enable and write-data pins, and returns load data or completion as a one-cycle response pulse. Sits between the core datapath and data memory, and is the only master of the memory port.

## Interface
- AW, 8, memory address width; depth = 2**AW
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- ReqValid  input  1  request present
- ReqReady  output  1  controller can accept a request
- ReqOp  input  2  00 LOAD, 01 STORE, 10 FILL, 11 reserved
- ReqAddr  input  AW  target / start address
- ReqData  input  8  store data / fill value
- ReqLen  input  AW  FILL word count (0 = no writes)
- RespValid  output  1  one-cycle completion pulse
- RespData  output  8  LOAD result, valid with RespValid (0 for other ops)
- RespErr  output  1  set with RespValid for reserved op
- MemAddress  output  AW  memory address
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- MemWData  output  8  memory write data
- MemRData  input  8  memory read data (combinational from memory; Z when MemRead low)

## Operation
- States: IDLE, READ, WRITE, FILL, RESP.
- ReqReady = 1 only in IDLE; handshake when ReqValid && ReqReady; request fields latched on that edge.
- IDLE → READ (LOAD), WRITE (STORE), FILL (FILL, ReqLen ≠ 0), RESP (FILL with ReqLen = 0, or reserved op with RespErr).
- READ: MemRead = 1, MemAddress = latched addr; MemRData captured into RespData at end of cycle; → RESP.
- WRITE: MemWrite = 1, MemAddress/MemWData = latched values; → RESP.
- FILL: MemWrite = 1 each cycle; address counter starts at ReqAddr, increments by 1 mod 2**AW (wraps 2**AW−1 → 0); remaining count decrements; → RESP after the write where count reaches 0.
- RESP: RespValid = 1 one cycle; → IDLE. No response backpressure.
- MemRead and MemWrite never high together; both low in IDLE and RESP. MemRData sampled only in READ.
- Reserved op: no memory access, RespErr = 1, RespData = 0.

## Timing
- Reset: state IDLE, ReqReady = 1, RespValid/RespErr/MemRead/MemWrite = 0, RespData/MemAddress/MemWData/count = 0.
- Handshake at edge T. LOAD: MemRead high cycle T+1, RespValid cycle T+2. STORE: memory written at end of T+1, RespValid T+2. FILL of N: writes in T+1..T+N, RespValid T+N+1.
- Next request accepted no earlier than the cycle after RespValid (minimum 3-cycle spacing for LOAD/STORE).
- All memory-side outputs registered or decoded from state registers only; no combinational path from Req* to Mem*.
- RST_N low mid-operation: MemWrite/MemRead drop immediately (asynchronously), remaining FILL writes abandoned, no RespValid for the aborted request.
- ReqValid while not ready: ignored; requester holds fields stable until accepted.

## Structure
- Package mem_ctrl_pkg: op enum (OP_LOAD, OP_STORE, OP_FILL, OP_RSVD), state enum, AW default constant.
- Single module, no sub-module; address counter and length counter inline.

## Test plan
- Reset release: all outputs at reset values, ReqReady = 1, MemRead = MemWrite = 0.
- STORE addr 0x10 data 0xA5, then LOAD addr 0x10 → MemWrite pulse at T+1, later RespValid with RespData = 0xA5 at LOAD T+2.
- FILL addr 0xFE len 4 value 0x3C → writes 0xFE, 0xFF, 0x00, 0x01 on four consecutive cycles, RespValid on fifth; LOAD 0x00 returns 0x3C.
- FILL len 0 → no MemWrite, RespValid at T+1; reserved op 11 → RespValid with RespErr = 1, RespData = 0, no memory access.
- ReqValid held high with back-to-back LOADs → ReqReady low during READ/RESP, each request accepted exactly once, responses in order.
- RST_N asserted during FILL len 8 after 3 writes → MemWrite low immediately, addresses 4–8 unwritten, no RespValid, ReqReady = 1 after release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory port controller: request opcodes, FSM states
// and the default address width.
package mem_ctrl_pkg;

    localparam int unsigned AW_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StFill,
        StResp
    } state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// Initiator-side controller for the CPU data memory: one request at a time over
// valid/ready, single-cycle load/store, multi-cycle block fill, one-cycle response.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [1:0]    ReqOp,
    input  logic [AW-1:0] ReqAddr,
    input  logic [7:0]    ReqData,
    input  logic [AW-1:0] ReqLen,
    output logic          RespValid,
    output logic [7:0]    RespData,
    output logic          RespErr,
    output logic [AW-1:0] MemAddress,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [7:0]    MemWData,
    input  logic [7:0]    MemRData
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] count_q, count_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    wdata_d = ReqData;
                    count_d = ReqLen;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    unique case (op_e'(ReqOp))
                        OP_LOAD:  state_d = StRead;
                        OP_STORE: state_d = StWrite;
                        OP_FILL:  state_d = (ReqLen == '0) ? StResp : StFill;
                        OP_RSVD: begin
                            state_d = StResp;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            StRead: begin
                rdata_d = MemRData;
                state_d = StResp;
            end
            StWrite: state_d = StResp;
            StFill: begin
                // Address wraps naturally at 2**AW; the write of count 1 is the last one.
                addr_d  = addr_q + AW'(1);
                count_d = count_q - AW'(1);
                if (count_q == AW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory-side outputs come straight from state registers, so reset drops them at once.
    assign ReqReady   = (state_q == StIdle);
    assign RespValid  = (state_q == StResp);
    assign RespErr    = (state_q == StResp) && err_q;
    assign RespData   = rdata_q;
    assign MemRead    = (state_q == StRead);
    assign MemWrite   = (state_q == StWrite) || (state_q == StFill);
    assign MemAddress = addr_q;
    assign MemWData   = wdata_q;

endmodule
